// File: rtl/ext_pkg.sv
// Shared extension-op encodings and default widths for the immediate extender pipeline.
package ext_pkg;

  typedef enum logic [1:0] {
    EOP_SEXT    = 2'b00,
    EOP_ZEXT    = 2'b01,
    EOP_LUI     = 2'b10,
    EOP_SEXT_SH = 2'b11
  } eop_e;

  localparam int DEF_IN_W  = 16;
  localparam int DEF_OUT_W = 32;
  localparam int DEF_SHIFT = 2;
  localparam int DEF_CNT_W = 8;

endpackage

// File: rtl/ext_core.sv
// Combinational immediate extender: sign/zero extend, upper-load and
// sign-extend-then-shift with overflow detection on the shifted-out bits.
module ext_core
  import ext_pkg::*;
#(
  parameter int IN_W  = DEF_IN_W,
  parameter int OUT_W = DEF_OUT_W,
  parameter int SHIFT = DEF_SHIFT
) (
  input  logic [IN_W-1:0]  imm,
  input  logic [1:0]       eop,
  output logic [OUT_W-1:0] data,
  output logic             ovf
);

  logic [OUT_W-1:0]       w_sext;
  logic [OUT_W-1:0]       w_zext;
  logic [OUT_W-1:0]       w_lui;
  logic [OUT_W+SHIFT-1:0] w_wide;
  logic [OUT_W+SHIFT-1:0] w_shifted;
  logic [OUT_W-1:0]       w_shData;
  logic                   w_shOvf;

  generate
    if (OUT_W > IN_W) begin : g_pad
      assign w_sext = {{(OUT_W-IN_W){imm[IN_W-1]}}, imm};
      assign w_zext = {{(OUT_W-IN_W){1'b0}}, imm};
      assign w_lui  = {imm, {(OUT_W-IN_W){1'b0}}};
    end else begin : g_same
      assign w_sext = imm;
      assign w_zext = imm;
      assign w_lui  = imm;
    end
  endgenerate

  // The bits pushed above OUT_W must all match the new sign bit, otherwise the shift overflowed.
  generate
    if (SHIFT > 0) begin : g_shift
      assign w_wide  = {{SHIFT{w_sext[OUT_W-1]}}, w_sext};
      assign w_shOvf = |(w_shifted[OUT_W+SHIFT-1:OUT_W] ^ {SHIFT{w_shifted[OUT_W-1]}});
    end else begin : g_noshift
      assign w_wide  = w_sext;
      assign w_shOvf = 1'b0;
    end
  endgenerate

  assign w_shifted = w_wide << SHIFT;
  assign w_shData  = w_shifted[OUT_W-1:0];

  always_comb begin
    data = w_sext;
    ovf  = 1'b0;
    case (eop_e'(eop))
      EOP_SEXT:    data = w_sext;
      EOP_ZEXT:    data = w_zext;
      EOP_LUI:     data = w_lui;
      EOP_SEXT_SH: begin
        data = w_shData;
        ovf  = w_shOvf;
      end
      default:     data = w_sext;
    endcase
  end

endmodule

// File: rtl/ext_pipe.sv
// Registered immediate extender with a 2-entry output skid buffer and a
// saturating debug counter of overflowing pushes.
module ext_pipe
  import ext_pkg::*;
#(
  parameter int IN_W  = DEF_IN_W,
  parameter int OUT_W = DEF_OUT_W,
  parameter int SHIFT = DEF_SHIFT,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [1:0]       in_eop,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_ovf,
  output logic [CNT_W-1:0] ovf_cnt,
  input  logic             ovf_clr
);

  logic [OUT_W-1:0] r_data [2];
  logic             r_ovf  [2];
  logic             r_head;
  logic             r_tail;
  logic [1:0]       r_count;
  logic [CNT_W-1:0] r_ovfCnt;

  logic [OUT_W-1:0] w_extData;
  logic             w_extOvf;
  logic             w_push;
  logic             w_pop;

  ext_core #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W),
    .SHIFT (SHIFT)
  ) u_core (
    .imm  (in_imm),
    .eop  (in_eop),
    .data (w_extData),
    .ovf  (w_extOvf)
  );

  // in_ready depends only on registered occupancy so downstream stalls never reach upstream combinationally.
  assign in_ready  = (r_count != 2'd2) && rst_n;
  assign out_valid = (r_count != 2'd0);
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;
  assign out_data  = out_valid ? r_data[r_head] : '0;
  assign out_ovf   = out_valid && r_ovf[r_head];
  assign ovf_cnt   = r_ovfCnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_data[0] <= '0;
      r_data[1] <= '0;
      r_ovf[0]  <= 1'b0;
      r_ovf[1]  <= 1'b0;
      r_head    <= 1'b0;
      r_tail    <= 1'b0;
      r_count   <= 2'd0;
      r_ovfCnt  <= '0;
    end else begin
      if (w_push) begin
        r_data[r_tail] <= w_extData;
        r_ovf[r_tail]  <= w_extOvf;
        r_tail         <= ~r_tail;
      end
      if (w_pop) begin
        r_head <= ~r_head;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
      // Clear wins over a same-cycle increment.
      if (ovf_clr) begin
        r_ovfCnt <= '0;
      end else if (w_push && w_extOvf && (r_ovfCnt != {CNT_W{1'b1}})) begin
        r_ovfCnt <= r_ovfCnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_ext_pipe.sv
// Self-checking bench for ext_pipe: a default-width instance and a 16/16-bit,
// 2-bit-counter instance, both compared each cycle against a queue-based model.
module tb_ext_pipe;
  import ext_pkg::*;

  logic clk;
  logic rst_n;

  logic        inValid  [2];
  logic        outReady [2];
  logic        ovfClr   [2];
  logic [15:0] inImm    [2];
  logic [1:0]  inEop    [2];
  logic        inReady  [2];
  logic        outValid [2];
  logic        outOvf   [2];
  logic [31:0] outDataA;
  logic [15:0] outDataB;
  logic [7:0]  ovfCntA;
  logic [1:0]  ovfCntB;

  bit          nV   [2];
  bit          nRdy [2];
  bit          nClr [2];
  logic [15:0] nImm [2];
  logic [1:0]  nOp  [2];

  longint qData [2][$];
  bit     qOvf  [2][$];
  int     mCnt  [2];
  int     cfgOut    [2] = '{32, 16};
  int     cfgCntMax [2] = '{255, 3};
  string  nm        [2] = '{"a", "b"};

  int checks   = 0;
  int failures = 0;

  ext_pipe u_dutA (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (inValid[0]),
    .in_ready  (inReady[0]),
    .in_imm    (inImm[0]),
    .in_eop    (inEop[0]),
    .out_valid (outValid[0]),
    .out_ready (outReady[0]),
    .out_data  (outDataA),
    .out_ovf   (outOvf[0]),
    .ovf_cnt   (ovfCntA),
    .ovf_clr   (ovfClr[0])
  );

  ext_pipe #(
    .IN_W  (16),
    .OUT_W (16),
    .SHIFT (2),
    .CNT_W (2)
  ) u_dutB (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (inValid[1]),
    .in_ready  (inReady[1]),
    .in_imm    (inImm[1]),
    .in_eop    (inEop[1]),
    .out_valid (outValid[1]),
    .out_ready (outReady[1]),
    .out_data  (outDataB),
    .out_ovf   (outOvf[1]),
    .ovf_cnt   (ovfCntB),
    .ovf_clr   (ovfClr[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [63:0] obsData(input int d);
    return (d == 0) ? 64'(outDataA) : 64'(outDataB);
  endfunction

  function automatic logic [63:0] obsCnt(input int d);
    return (d == 0) ? 64'(ovfCntA) : 64'(ovfCntB);
  endfunction

  // Reference: true signed value of the immediate, plain arithmetic, overflow = result not representable.
  function automatic void extModel(input int d, input logic [15:0] im, input logic [1:0] op,
                                   output longint data, output bit ovf);
    longint s, v, lim, mask;
    int outW;
    outW = cfgOut[d];
    mask = (longint'(1) << outW) - 1;
    lim  = longint'(1) << (outW - 1);
    s    = longint'(im);
    if (im[15]) s = s - 65536;
    ovf  = 1'b0;
    case (op)
      2'b00:   data = s & mask;
      2'b01:   data = longint'(im);
      2'b10:   data = (longint'(im) << (outW - 16)) & mask;
      default: begin
        v    = s * 4;
        data = v & mask;
        ovf  = (v >= lim) || (v < -lim);
      end
    endcase
  endfunction

  task automatic checkAll();
    for (int d = 0; d < 2; d++) begin
      bit ev;
      ev = (qData[d].size() != 0);
      checkOutput({nm[d], "_valid"}, 64'(outValid[d]), 64'(ev));
      checkOutput({nm[d], "_data"},  obsData(d), ev ? 64'(qData[d][0]) : 64'd0);
      checkOutput({nm[d], "_ovf"},   64'(outOvf[d]), ev ? 64'(qOvf[d][0]) : 64'd0);
      checkOutput({nm[d], "_ready"}, 64'(inReady[d]), 64'(qData[d].size() < 2));
      checkOutput({nm[d], "_cnt"},   obsCnt(d), 64'(mCnt[d]));
    end
  endtask

  task automatic setIn(input int d, input bit v, input logic [15:0] im, input logic [1:0] op,
                       input bit rdy, input bit clr);
    nV[d]   = v;
    nImm[d] = im;
    nOp[d]  = op;
    nRdy[d] = rdy;
    nClr[d] = clr;
  endtask

  task automatic applyStimulus();
    longint dv;
    bit     ov, push, pop;
    @(negedge clk);
    checkAll();
    rst_n = 1'b1;
    for (int d = 0; d < 2; d++) begin
      inValid[d]  = nV[d];
      inImm[d]    = nImm[d];
      inEop[d]    = nOp[d];
      outReady[d] = nRdy[d];
      ovfClr[d]   = nClr[d];
      push = nV[d] && (qData[d].size() < 2);
      pop  = (qData[d].size() > 0) && nRdy[d];
      extModel(d, nImm[d], nOp[d], dv, ov);
      if (pop) begin
        void'(qData[d].pop_front());
        void'(qOvf[d].pop_front());
      end
      if (push) begin
        qData[d].push_back(dv);
        qOvf[d].push_back(ov);
      end
      if (nClr[d]) mCnt[d] = 0;
      else if (push && ov && (mCnt[d] < cfgCntMax[d])) mCnt[d]++;
    end
  endtask

  task automatic idleAll();
    for (int d = 0; d < 2; d++) begin
      setIn(d, 1'b0, 16'h0, 2'b00, 1'b0, 1'b0);
      inValid[d]  = 1'b0;
      inImm[d]    = 16'h0;
      inEop[d]    = 2'b00;
      outReady[d] = 1'b0;
      ovfClr[d]   = 1'b0;
      qData[d].delete();
      qOvf[d].delete();
      mCnt[d] = 0;
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    checkAll();
    rst_n = 1'b0;
    idleAll();
    #1;
    checkOutput("a_ready_in_reset", 64'(inReady[0]), 64'd0);
    checkOutput("b_ready_in_reset", 64'(inReady[1]), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkAll();
  endtask

  logic [15:0] planImm [4] = '{16'h8000, 16'h8000, 16'h1234, 16'hFFFF};
  logic [1:0]  planOp  [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
  logic [31:0] planExp [4] = '{32'hFFFF8000, 32'h00008000, 32'h12340000, 32'hFFFFFFFC};

  initial begin
    rst_n = 1'b0;
    idleAll();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkAll();

    for (int i = 0; i < 4; i++) begin
      setIn(0, 1'b1, planImm[i], planOp[i], 1'b1, 1'b0);
      applyStimulus();
      setIn(0, 1'b0, 16'h0, 2'b00, 1'b1, 1'b0);
      applyStimulus();
      checkOutput("plan_data", 64'(outDataA), 64'(planExp[i]));
      checkOutput("plan_ovf", 64'(outOvf[0]), 64'd0);
    end

    setIn(0, 1'b1, 16'h1111, 2'b00, 1'b0, 1'b0);
    applyStimulus();
    setIn(0, 1'b1, 16'h2222, 2'b01, 1'b0, 1'b0);
    applyStimulus();
    setIn(0, 1'b1, 16'h3333, 2'b10, 1'b0, 1'b0);
    applyStimulus();
    checkOutput("full_ready", 64'(inReady[0]), 64'd0);
    applyStimulus();
    checkOutput("full_head", 64'(outDataA), 64'h1111);
    setIn(0, 1'b1, 16'h3333, 2'b10, 1'b1, 1'b0);
    applyStimulus();
    applyStimulus();
    setIn(0, 1'b0, 16'h0, 2'b00, 1'b1, 1'b0);
    repeat (3) applyStimulus();
    checkOutput("drain_valid", 64'(outValid[0]), 64'd0);

    setIn(0, 1'b1, 16'h0100, 2'b00, 1'b0, 1'b0);
    applyStimulus();
    for (int k = 0; k < 10; k++) begin
      setIn(0, 1'b1, 16'(16'h0101 + k), 2'b01, 1'b1, 1'b0);
      applyStimulus();
      checkOutput("stream_ready", 64'(inReady[0]), 64'd1);
      if (k > 0) checkOutput("stream_data", 64'(outDataA), 64'(16'h0101 + k - 1));
    end
    setIn(0, 1'b0, 16'h0, 2'b00, 1'b1, 1'b0);
    repeat (3) applyStimulus();

    setIn(1, 1'b1, 16'h4000, 2'b11, 1'b1, 1'b0);
    applyStimulus();
    setIn(1, 1'b0, 16'h0, 2'b00, 1'b1, 1'b0);
    applyStimulus();
    checkOutput("b_sh_data", 64'(outDataB), 64'h0000);
    checkOutput("b_sh_ovf", 64'(outOvf[1]), 64'd1);
    checkOutput("b_sh_cnt", 64'(ovfCntB), 64'd1);
    setIn(1, 1'b1, 16'hE000, 2'b11, 1'b1, 1'b0);
    applyStimulus();
    setIn(1, 1'b0, 16'h0, 2'b00, 1'b1, 1'b0);
    applyStimulus();
    checkOutput("b_sh2_data", 64'(outDataB), 64'h8000);
    checkOutput("b_sh2_ovf", 64'(outOvf[1]), 64'd0);

    setIn(1, 1'b1, 16'h4000, 2'b11, 1'b1, 1'b0);
    repeat (5) applyStimulus();
    setIn(1, 1'b0, 16'h0, 2'b00, 1'b1, 1'b0);
    applyStimulus();
    checkOutput("b_cnt_sat", 64'(ovfCntB), 64'd3);
    setIn(1, 1'b1, 16'h4000, 2'b11, 1'b1, 1'b1);
    applyStimulus();
    setIn(1, 1'b0, 16'h0, 2'b00, 1'b1, 1'b0);
    applyStimulus();
    checkOutput("b_cnt_clr", 64'(ovfCntB), 64'd0);

    setIn(1, 1'b1, 16'h4000, 2'b11, 1'b0, 1'b0);
    setIn(0, 1'b1, 16'hAAAA, 2'b00, 1'b0, 1'b0);
    applyStimulus();
    setIn(1, 1'b0, 16'h0, 2'b00, 1'b0, 1'b0);
    setIn(0, 1'b1, 16'hBBBB, 2'b01, 1'b0, 1'b0);
    applyStimulus();
    setIn(0, 1'b0, 16'h0, 2'b00, 1'b0, 1'b0);
    applyStimulus();
    checkOutput("prerst_ready", 64'(inReady[0]), 64'd0);
    checkOutput("prerst_cnt", 64'(ovfCntB), 64'd1);
    doReset();
    checkOutput("rst_valid", 64'(outValid[0]), 64'd0);
    checkOutput("rst_data", 64'(outDataA), 64'd0);
    checkOutput("rst_cnt", 64'(ovfCntB), 64'd0);
    checkOutput("rst_ready", 64'(inReady[0]), 64'd1);
    setIn(0, 1'b1, 16'h00AB, 2'b01, 1'b1, 1'b0);
    applyStimulus();
    setIn(0, 1'b0, 16'h0, 2'b00, 1'b1, 1'b0);
    applyStimulus();
    checkOutput("postrst_data", 64'(outDataA), 64'h00AB);

    for (int c = 0; c < 400; c++) begin
      for (int d = 0; d < 2; d++) begin
        setIn(d, $urandom_range(3) != 0, 16'($urandom), 2'($urandom_range(3)),
              $urandom_range(2) != 0, $urandom_range(15) == 0);
      end
      applyStimulus();
    end
    setIn(0, 1'b0, 16'h0, 2'b00, 1'b1, 1'b0);
    setIn(1, 1'b0, 16'h0, 2'b00, 1'b1, 1'b0);
    repeat (4) applyStimulus();
    @(negedge clk);
    checkAll();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
